stopwatch_ctrl: RTL and testbench

Button-driven control FSM that sequences the centisecond stopwatch datapath on the Nexys A7. It debounces two raw push-buttons and turns their presses into the datapath's `start` (run) level, a stretched `reset` (clear) level and a lap-freeze level for the 7-segment path. Clear is stretched because the datapath samples its controls only on the slow 1-centisecond clock. The block sits between the board buttons and the stopwatch, in the 100 MHz `clk` domain.

---
 rtl/stopwatch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Button-driven control FSM for the centisecond stopwatch datapath: synchronizes and debounces two
// buttons, sequences run/clear/lap-hold. Optional LAP state enabled by STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CLEAR_CYCLES    = 1000004
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       run,
    output logic       clear,
    output logic       lap_hold,
    output logic [2:0] state
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ClrW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRunning  = 3'd1,
        StPaused   = 3'd2,
        StLap      = 3'd3,
        StClearing = 3'd4
    } state_e;

    // Index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     level_q, level_d;
    logic [1:0]     press_q, press_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];

    assign btn_raw = {btn_lr, btn_ss};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // The level flips on the cycle the count would reach DEBOUNCE_CYCLES; a rising flip is a press.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_e          state_q, state_d;
    logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
    logic            press_ss, press_lr;

    assign press_ss = press_q[0];
    assign press_lr = press_q[1];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        case (state_q)
            StIdle: begin
                if (press_ss) begin
                    state_d = StRunning;
                end else if (press_lr) begin
                    state_d = StClearing;
                end
            end
            StRunning: begin
                if (press_ss) begin
                    state_d = StPaused;
`ifdef STOPWATCH_CTRL_LAP_EN
                end else if (press_lr) begin
                    state_d = StLap;
`endif
                end
            end
`ifdef STOPWATCH_CTRL_LAP_EN
            StLap: begin
                if (press_ss) begin
                    state_d = StPaused;
                end else if (press_lr) begin
                    state_d = StRunning;
                end
            end
`endif
            StPaused: begin
                if (press_ss) begin
                    state_d = StRunning;
                end else if (press_lr) begin
                    state_d = StClearing;
                end
            end
            StClearing: begin
                if (clr_cnt_q == ClrLast) begin
                    state_d = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = StClearing;
        endcase
    end

    logic run_q, clear_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StClearing;
            clr_cnt_q <= '0;
            run_q     <= 1'b0;
            clear_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            run_q     <= (state_d == StRunning) || (state_d == StLap);
            clear_q   <= (state_d == StClearing);
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= (state_d == StLap);
        end
    end

    assign lap_hold = lap_q;
`else
    assign lap_hold = 1'b0;
`endif

    assign run   = run_q;
    assign clear = clear_q;
    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_ss;
    logic       btn_lr;
    logic       run;
    logic       clear;
    logic       lap_hold;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CLEAR_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .run     (run),
        .clear   (clear),
        .lap_hold(lap_hold),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All stimulus changes and samples happen on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input bit is_ss);
        if (is_ss) btn_ss = 1'b1;
        else       btn_lr = 1'b1;
        step(10);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(10);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic r,
                              input logic c, input logic l);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_run"}, 32'(run), 32'(r));
        check({tag, "_clear"}, 32'(clear), 32'(c));
        check({tag, "_lap"}, 32'(lap_hold), 32'(l));
    endtask

    logic glitch [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(2);
        check_outs("in_reset", 3'd4, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(7);
        check_outs("rst_clear7", 3'd4, 1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("rst_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Glitches of 1 and 3 cycles must not be accepted.
        for (int i = 0; i < 7; i++) begin
            btn_ss = glitch[i];
            step(1);
        end
        btn_ss = 1'b1;
        step(6);
        check_outs("ss_lat6", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("ss_lat7", 3'd1, 1'b1, 1'b0, 1'b0);
        step(3);
        btn_ss = 1'b0;
        step(10);
        check("ss_one_press", 32'(state), 32'd1);

`ifdef STOPWATCH_CTRL_LAP_EN
        press_btn(1'b0);
        check_outs("lap1", 3'd3, 1'b1, 1'b0, 1'b1);
        press_btn(1'b0);
        check_outs("lap_back", 3'd1, 1'b1, 1'b0, 1'b0);
        press_btn(1'b0);
        check_outs("lap2", 3'd3, 1'b1, 1'b0, 1'b1);
        press_btn(1'b1);
        check_outs("lap_pause", 3'd2, 1'b0, 1'b0, 1'b0);
`else
        press_btn(1'b0);
        check_outs("nolap_lr", 3'd1, 1'b1, 1'b0, 1'b0);
        press_btn(1'b1);
        check_outs("pause", 3'd2, 1'b0, 1'b0, 1'b0);
`endif

        // Clear from PAUSED, with an ss press landing mid-clear.
        btn_lr = 1'b1;
        step(6);
        check("clr_pre", 32'(state), 32'd2);
        step(1);
        check_outs("clr_enter", 3'd4, 1'b0, 1'b1, 1'b0);
        btn_ss = 1'b1;
        step(3);
        btn_lr = 1'b0;
        step(4);
        check_outs("clr_last", 3'd4, 1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("clr_done", 3'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        btn_ss = 1'b0;
        step(10);
        check("clr_ss_dropped", 32'(state), 32'd0);

        // Simultaneous presses from PAUSED: ss wins.
        press_btn(1'b1);
        press_btn(1'b1);
        check("sim_pre", 32'(state), 32'd2);
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        step(10);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(10);
        check_outs("sim_run", 3'd1, 1'b1, 1'b0, 1'b0);

        // Reset at clear count 5 restarts a full clear.
        press_btn(1'b1);
        btn_lr = 1'b1;
        step(7);
        check("mid_enter", 32'(state), 32'd4);
        btn_lr = 1'b0;
        step(5);
        reset = 1'b1;
        step(1);
        check_outs("mid_rst", 3'd4, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(7);
        check_outs("mid_clear7", 3'd4, 1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("mid_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
